// File: rtl/core_sel_pkg.sv
// Shared types and helpers for the grant selection logic.
// Used by the selector top, its search stages and the handshake interface.
package core_sel_pkg;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  // $clog2(2) is 1 but $clog2(1) is 0, so clamp to keep index buses non-empty.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_grant_selector_if.sv
// Request/grant bundle between requesters, the selector and the consumer.
// The slave side belongs to the selector; the master side drives requests and ready.
interface multi_grant_selector_if #(
  parameter int WIDTH  = 8,
  parameter int GRANTS = 2,
  localparam int IDX_W = core_sel_pkg::idx_width(WIDTH)
) ();

  logic [WIDTH-1:0]              req;
  logic                          rr_mode;
  logic                          grant_ready;
  logic [GRANTS-1:0]             grant_valid;
  logic [GRANTS-1:0][IDX_W-1:0]  grant_idx;
  logic [WIDTH-1:0]              grant_onehot;
  logic [IDX_W-1:0]              rr_ptr;

  modport slave (
    input  req, rr_mode, grant_ready,
    output grant_valid, grant_idx, grant_onehot, rr_ptr
  );

  modport master (
    output req, rr_mode, grant_ready,
    input  grant_valid, grant_idx, grant_onehot, rr_ptr
  );

endinterface

// File: rtl/rr_find_first.sv
// Finds the first set bit of a mask in either fixed (high index first) or
// rotating order starting at a given index; wrap is by compare, not by masking.
module rr_find_first
  import core_sel_pkg::*;
#(
  parameter int WIDTH  = 8,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  input  logic [IDX_W-1:0] i_start,
  input  sel_mode_e        i_dir,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    int pos;
    pos     = 0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i_dir == SEL_FIXED) begin
        pos = WIDTH - 1 - k;
      end else begin
        pos = int'(i_start) + k;
        if (pos >= WIDTH) pos = pos - WIDTH;
      end
      if (!o_found && i_mask[pos]) begin
        o_found = 1'b1;
        o_idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/multi_grant_selector.sv
// Multi-grant issue/wakeup selector: up to GRANTS picks per cycle from a request
// vector, fixed or round-robin order, held in an output register with valid/ready.
module multi_grant_selector
  import core_sel_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GRANTS = 2,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_grant_selector_if.slave  bus
);

  logic [GRANTS-1:0]             r_valid;
  logic [GRANTS-1:0][IDX_W-1:0]  r_idx;
  logic [WIDTH-1:0]              r_onehot;
  logic [IDX_W-1:0]              r_ptr;

  logic                          w_load;
  sel_mode_e                     w_mode;
  logic [WIDTH-1:0]              w_elig;
  logic [WIDTH-1:0]              w_mask [GRANTS];
  logic [WIDTH-1:0]              w_pick [GRANTS];
  logic [GRANTS-1:0]             w_found;
  logic [GRANTS-1:0][IDX_W-1:0]  w_idx;
  logic [WIDTH-1:0]              w_onehot;
  logic [IDX_W-1:0]              w_last;
  logic [IDX_W-1:0]              w_next_ptr;

  assign w_mode = sel_mode_e'(bus.rr_mode);
  assign w_load = ~(|r_valid) | bus.grant_ready;
  // Held grants are masked so a requester being consumed this cycle is not re-granted.
  assign w_elig = bus.req & ~r_onehot;

  for (genvar g = 0; g < GRANTS; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign w_mask[g] = w_elig;
    end else begin : g_next
      assign w_mask[g] = w_mask[g-1] & ~w_pick[g-1];
    end

    rr_find_first #(.WIDTH(WIDTH)) u_find (
      .i_mask  (w_mask[g]),
      .i_start (r_ptr),
      .i_dir   (w_mode),
      .o_idx   (w_idx[g]),
      .o_found (w_found[g])
    );

    assign w_pick[g] = w_found[g] ? (WIDTH'(1) << w_idx[g]) : '0;
  end

  always_comb begin
    w_onehot = '0;
    w_last   = '0;
    for (int g = 0; g < GRANTS; g++) begin
      w_onehot = w_onehot | w_pick[g];
      if (w_found[g]) w_last = w_idx[g];
    end
    w_next_ptr = (int'(w_last) + 1 >= WIDTH) ? '0 : w_last + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else if (w_load) begin
      r_valid  <= w_found;
      r_idx    <= w_idx;
      r_onehot <= w_onehot;
      if (w_mode == SEL_RR && |w_found) r_ptr <= w_next_ptr;
    end
  end

  assign bus.grant_valid  = r_valid;
  assign bus.grant_idx    = r_idx;
  assign bus.grant_onehot = r_onehot;
  assign bus.rr_ptr       = r_ptr;

endmodule
